// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared key-handling types and default timing constants
// Contents: filter FSM state encoding, 50 MHz timing defaults, max_int helper.
// Shared by key_debounce and key_counter.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE           = 2'd0,
      PRESS_FILTER   = 2'd1,
      DOWN           = 2'd2,
      RELEASE_FILTER = 2'd3
   } key_fsm_e;

   localparam int DEBOUNCE_20MS_50MHZ = 1_000_000;
   localparam int REPEAT_500MS_50MHZ  = 25_000_000;
   localparam int REPEAT_100MS_50MHZ  = 5_000_000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - two-flop synchroniser for an asynchronous level, resets high
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   din  in  asynchronous input level
//   dout out synchronised level (two clocks of latency)
module key_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic sync0;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync0 <= 1'b1;
         dout  <= 1'b1;
      end else begin
         sync0 <= din;
         dout  <= sync0;
      end
   end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - active-low push-button debouncer with press/release strobes
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat key_press while held).
// Ports:
//   clk_50mhz   in  system clock
//   rst         in  synchronous active-high reset
//   key_in      in  raw asynchronous button level, 0 = pressed
//   key_state   out debounced level, 0 = pressed
//   key_press   out one-cycle strobe on accepted press (and each auto-repeat)
//   key_release out one-cycle strobe on accepted release
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_20MS_50MHZ,
   parameter int REPEAT_DELAY    = REPEAT_500MS_50MHZ,
   parameter int REPEAT_PERIOD   = REPEAT_100MS_50MHZ
) (
   input  logic clk_50mhz,
   input  logic rst,
   input  logic key_in,
   output logic key_state,
   output logic key_press,
   output logic key_release
);

`ifdef KEY_AUTO_REPEAT_EN
   localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, max_int(REPEAT_DELAY, REPEAT_PERIOD));
`else
   localparam int CNT_MAX = DEBOUNCE_CYCLES;
`endif
   localparam int CNT_W = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be >= 2");
   end
   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic             key_sync_q;
   key_fsm_e         state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             key_state_nxt, press_nxt, release_nxt;

   key_sync u_sync (
      .clk  (clk_50mhz),
      .rst  (rst),
      .din  (key_in),
      .dout (key_sync_q)
   );

`ifdef KEY_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   // Set once the first auto-repeat has fired; switches the DOWN hold
   // counter from the initial delay to the repeat period.
   logic repeating, repeating_nxt;

   always_ff @(posedge clk_50mhz) begin
      if (rst) repeating <= 1'b0;
      else     repeating <= repeating_nxt;
   end
`endif

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         key_state   <= 1'b1;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         key_state   <= key_state_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
      end
   end

   // cnt is cleared on every state change, so it never has to wrap.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      key_state_nxt = key_state;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      repeating_nxt = repeating;
`endif
      case (state)
         IDLE: begin
            if (!key_sync_q) begin
               state_nxt = PRESS_FILTER;
               cnt_nxt   = '0;
            end
         end
         PRESS_FILTER: begin
            if (key_sync_q) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == DB_LAST) begin
               state_nxt     = DOWN;
               cnt_nxt       = '0;
               key_state_nxt = 1'b0;
               press_nxt     = 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
               repeating_nxt = 1'b0;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DOWN: begin
            if (key_sync_q) begin
               state_nxt = RELEASE_FILTER;
               cnt_nxt   = '0;
`ifdef KEY_AUTO_REPEAT_EN
               repeating_nxt = 1'b0;
            end else if (cnt == (repeating ? PER_LAST : DLY_LAST)) begin
               cnt_nxt       = '0;
               press_nxt     = 1'b1;
               repeating_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
`endif
            end
         end
         RELEASE_FILTER: begin
            if (!key_sync_q) begin
               // Bounce back to held: the repeat delay starts over.
               state_nxt = DOWN;
               cnt_nxt   = '0;
`ifdef KEY_AUTO_REPEAT_EN
               repeating_nxt = 1'b0;
`endif
            end else if (cnt == DB_LAST) begin
               state_nxt     = IDLE;
               cnt_nxt       = '0;
               key_state_nxt = 1'b1;
               release_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce with a run-length reference model
module tb_key_debounce;

   localparam int D  = 500;
   localparam int RD = 2000;
   localparam int RP = 500;

   logic clk_50mhz = 1'b0;
   logic rst       = 1'b1;
   logic key_in    = 1'b1;
   logic key_state, key_press, key_release;

   key_debounce #(
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk_50mhz   (clk_50mhz),
      .rst         (rst),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic chk(input string name, input int got, input int expv);
      n_cmp++;
      if (got !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   typedef struct {
      int cyc;
      bit is_press;
   } strobe_t;

   strobe_t exp_q[$];

   // Reference model: the filter sees key_in two clocks late; the debounced
   // level flips after D+1 consecutive samples at the opposite level.
   bit m_s0 = 1'b1, m_s1 = 1'b1, m_lvl = 1'b1, smp;
   int m_run = 0, m_t = 0;

   always @(posedge clk_50mhz) begin
      strobe_t e;
      cyc++;
      if (rst) begin
         m_s0 = 1'b1; m_s1 = 1'b1; m_lvl = 1'b1; m_run = 0; m_t = 0;
      end else begin
         smp  = m_s1;
         m_s1 = m_s0;
         m_s0 = key_in;
         if (smp != m_lvl) begin
            m_run++;
            if (m_run == D + 1) begin
               m_lvl = smp;
               m_run = 0;
               m_t   = 0;
               e.cyc = cyc;
               e.is_press = (smp == 1'b0);
               exp_q.push_back(e);
            end
         end else begin
            if (m_lvl == 1'b0) begin
               if (m_run > 0) m_t = 0;
               else begin
                  m_t++;
`ifdef KEY_AUTO_REPEAT_EN
                  if (m_t >= RD && ((m_t - RD) % RP) == 0) begin
                     e.cyc = cyc;
                     e.is_press = 1'b1;
                     exp_q.push_back(e);
                  end
`endif
               end
            end
            m_run = 0;
         end
      end
   end

   // Monitor
   int n_press = 0, n_rel = 0, last_press = 0, last_rel = 0;
   bit in_bounce = 1'b0;

   always @(negedge clk_50mhz) begin
      strobe_t e;
      if (key_press && key_release) chk("strobes_exclusive", 1, 0);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         chk("missed_strobe_cycle", -1, e.cyc);
      end
      if (key_press || key_release) begin
         if (in_bounce) chk("strobe_during_bounce", 1, 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe_cycle", cyc, -1);
         end else begin
            e = exp_q.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            chk("strobe_kind_press", int'(key_press), int'(e.is_press));
            chk("key_state_at_strobe", int'(key_state), int'(!e.is_press));
         end
         if (key_press) begin n_press++; last_press = cyc; end
         else begin n_rel++; last_rel = cyc; end
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk_50mhz);
   endtask

   initial begin
      int edge_c, base_p, base_r;

      // 1: reset state
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_50mhz);
         chk("rst_key_state", int'(key_state), 1);
         chk("rst_key_press", int'(key_press), 0);
         chk("rst_key_release", int'(key_release), 0);
      end
      rst = 1'b0;
      wait_cyc(20);
      chk("post_rst_key_state", int'(key_state), 1);
      chk("post_rst_press_count", n_press, 0);

      // 2: clean press and release
      key_in = 1'b0; edge_c = cyc + 1;
      wait_cyc(600);
      chk("clean_press_latency", last_press - edge_c, 502);
      chk("clean_press_count", n_press, 1);
      chk("clean_key_state_low", int'(key_state), 0);
      key_in = 1'b1; edge_c = cyc + 1;
      wait_cyc(600);
      chk("clean_release_latency", last_rel - edge_c, 502);
      chk("clean_release_count", n_rel, 1);
      chk("clean_key_state_high", int'(key_state), 1);

      // 3: bouncy press/release x3
      base_p = n_press; base_r = n_rel;
      for (int r = 0; r < 3; r++) begin
         in_bounce = 1'b1;
         for (int t = 0; t < 50; t++) begin
            key_in = ~key_in;
            wait_cyc($urandom_range(89, 1));
         end
         in_bounce = 1'b0;
         key_in = 1'b0;
         wait_cyc(600);
         in_bounce = 1'b1;
         for (int t = 0; t < 50; t++) begin
            key_in = ~key_in;
            wait_cyc($urandom_range(89, 1));
         end
         in_bounce = 1'b0;
         key_in = 1'b1;
         wait_cyc(600);
      end
      chk("bounce_press_count", n_press - base_p, 3);
      chk("bounce_release_count", n_rel - base_r, 3);

      // 4: glitches
      base_p = n_press; base_r = n_rel;
      key_in = 1'b0; wait_cyc(100);
      key_in = 1'b1; wait_cyc(600);
      chk("low_glitch_no_press", n_press - base_p, 0);
      chk("low_glitch_key_state", int'(key_state), 1);
      key_in = 1'b0; wait_cyc(600);
      key_in = 1'b1; wait_cyc(100);
      key_in = 1'b0; wait_cyc(600);
      chk("high_glitch_no_release", n_rel - base_r, 0);
      chk("high_glitch_key_state", int'(key_state), 0);
      key_in = 1'b1; wait_cyc(600);

      // 5: reset while PRESS_FILTER has counted to 300
      base_p = n_press;
      key_in = 1'b0;
      wait_cyc(303);
      rst = 1'b1;
      wait_cyc(5);
      chk("mid_rst_key_state", int'(key_state), 1);
      chk("mid_rst_no_press", n_press - base_p, 0);
      rst = 1'b0; edge_c = cyc + 1;
      wait_cyc(600);
      chk("after_rst_press_count", n_press - base_p, 1);
      chk("after_rst_press_latency", last_press - edge_c, 502);
      key_in = 1'b1; wait_cyc(600);

      // 6: long hold
      base_p = n_press;
      key_in = 1'b0; edge_c = cyc + 1;
      wait_cyc(3200);
`ifdef KEY_AUTO_REPEAT_EN
      chk("hold_press_count", n_press - base_p, 3);
      chk("hold_last_press", last_press - edge_c, 3002);
`else
      chk("hold_press_count", n_press - base_p, 1);
      chk("hold_last_press", last_press - edge_c, 502);
`endif
      key_in = 1'b1; wait_cyc(600);
      chk("final_key_state", int'(key_state), 1);

      wait_cyc(10);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
